// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: PHY-side frame decoder with a 32x16 register file.
// Drives read data in the TA/DATA window and reports writes and malformed frames.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd7,
  parameter bit          ACCEPT_BCAST = 1'b0,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [31:0] PHY_ID       = 32'h01410CC2,
  parameter logic [15:0] STATUS_RST   = 16'h7949
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mdc_i,
  input  logic        mdd_i,
  output logic        mdd_o,
  output logic        mdd_oe,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int PW = $clog2(PREAMBLE_MIN + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ST2, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_SKIP
  } state_t;

  state_t         state_q;
  logic [1:0]     mdc_sq;
  logic [1:0]     mdd_sq;
  logic           mdc_dq;
  logic [PW-1:0]  pre_q;
  logic [4:0]     fbit_q;
  logic           rd_q;
  logic           ta_q;
  logic           match_q;
  logic [4:0]     regad_q;
  logic [15:0]    sh_q;
  logic [15:0]    rf_q [32];

  logic re;
  logic b;
  logic [4:0] fld;
  assign re  = mdc_sq[1] & ~mdc_dq;
  assign b   = mdd_sq[1];
  assign fld = {sh_q[3:0], b};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mdc_sq    <= '0;
      mdd_sq    <= '0;
      mdc_dq    <= 1'b0;
      pre_q     <= '0;
      fbit_q    <= '0;
      rd_q      <= 1'b0;
      ta_q      <= 1'b0;
      match_q   <= 1'b0;
      regad_q   <= '0;
      sh_q      <= '0;
      mdd_o     <= 1'b0;
      mdd_oe    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      rf_q[1] <= STATUS_RST;
      rf_q[2] <= PHY_ID[31:16];
      rf_q[3] <= PHY_ID[15:0];
    end else begin
      mdc_sq    <= {mdc_sq[0], mdc_i};
      mdd_sq    <= {mdd_sq[0], mdd_i};
      mdc_dq    <= mdc_sq[1];
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (re) begin
        fbit_q <= fbit_q + 5'd1;
        unique case (state_q)
          S_IDLE: begin
            if (b) begin
              if (pre_q < PW'(PREAMBLE_MIN)) pre_q <= pre_q + 1'b1;
            end else if (pre_q >= PW'(PREAMBLE_MIN)) begin
              state_q <= S_ST2;
              busy    <= 1'b1;
              fbit_q  <= 5'd1;
              pre_q   <= '0;
            end else begin
              pre_q <= '0;
            end
          end
          S_ST2: begin
            if (b) begin
              state_q <= S_OP;
            end else begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          S_OP: begin
            sh_q <= {sh_q[14:0], b};
            if (fbit_q == 5'd3) begin
              if (sh_q[0] ^ b) begin
                rd_q    <= sh_q[0];
                state_q <= S_PHY;
              end else begin
                frame_err <= 1'b1;
                state_q   <= S_SKIP;
              end
            end
          end
          S_PHY: begin
            sh_q <= {sh_q[14:0], b};
            if (fbit_q == 5'd8) begin
              match_q <= (fld == PHY_ADDR) |
                         (ACCEPT_BCAST & (fld == 5'd0) & ~rd_q);
              state_q <= S_REG;
            end
          end
          S_REG: begin
            sh_q <= {sh_q[14:0], b};
            if (fbit_q == 5'd13) begin
              regad_q <= fld;
              state_q <= S_TA;
              // read data is frozen here, before TA begins
              if (rd_q) sh_q <= rf_q[fld];
            end
          end
          S_TA: begin
            if (fbit_q == 5'd14) begin
              ta_q <= b;
              if (rd_q & match_q) begin
                mdd_oe <= 1'b1;
                mdd_o  <= 1'b0;
              end
            end else if (rd_q) begin
              if (match_q) mdd_o <= sh_q[15];
              sh_q    <= {sh_q[14:0], 1'b0};
              state_q <= S_DATA;
            end else if (ta_q & ~b) begin
              state_q <= S_DATA;
            end else begin
              frame_err <= 1'b1;
              state_q   <= S_SKIP;
            end
          end
          S_DATA: begin
            if (rd_q) begin
              if (match_q) mdd_o <= sh_q[15];
              sh_q <= {sh_q[14:0], 1'b0};
            end else begin
              sh_q <= {sh_q[14:0], b};
            end
            if (fbit_q == 5'd31) begin
              mdd_oe  <= 1'b0;
              mdd_o   <= 1'b0;
              busy    <= 1'b0;
              state_q <= S_IDLE;
              if (~rd_q & match_q &
                  (regad_q != 5'd2) & (regad_q != 5'd3)) begin
                rf_q[regad_q] <= {sh_q[14:0], b};
                wr_valid      <= 1'b1;
                wr_addr       <= regad_q;
                wr_data       <= {sh_q[14:0], b};
              end
            end
          end
          S_SKIP: begin
            if (fbit_q == 5'd31) begin
              busy    <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
